spgd_step_accum: RTL and testbench

- Downstream consumer of the padded, offset-corrected Q16.48 step words: 64-bit signed, integer part in bits [63:48].
- Integrates each signed step, scaled by a programmable right shift, into a persistent actuator accumulator.
- Saturates the accumulator to the DAC range and presents a 12-bit DAC code with a valid/ready handshake.
- Forms the parameter-update stage of the SPGD loop, between step generation and the DAC driver.

---
 rtl/spgd_pkg.sv | 22 ++
 rtl/gen_adder.sv | 14 +
 rtl/spgd_step_accum.sv | 171 +++++++++++++++++
 tb/tb_spgd_step_accum.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared constants for the SPGD actuator accumulator.
// Contents: default widths, accumulator clamp limit and reset value,
// and the controller state encoding.
package spgd_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 64;
  localparam int unsigned FRAC_BITS_DEF   = 48;
  localparam int unsigned DAC_WIDTH_DEF   = 12;
  localparam int unsigned SHIFT_WIDTH     = 6;
  localparam int unsigned STATE_WIDTH     = 3;

  // Full-scale DAC code expressed in Q16.48, and mid-scale reset value.
  localparam logic [63:0] ACC_LIMIT_HI   = 64'h0FFF_0000_0000_0000;
  localparam logic [63:0] ACC_INIT_VALUE = 64'h0800_0000_0000_0000;

  localparam logic [STATE_WIDTH-1:0] IDLE    = 3'd0;
  localparam logic [STATE_WIDTH-1:0] SCALE   = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ADD     = 3'd2;
  localparam logic [STATE_WIDTH-1:0] CLAMP   = 3'd3;
  localparam logic [STATE_WIDTH-1:0] PRESENT = 3'd4;

endpackage

// File: rtl/gen_adder.sv
// Generic two's-complement adder with a one-bit-wider result so the sum
// never wraps; s[IN_WIDTH] is the sign of the true sum.
// Ports: a, b (IN_WIDTH, signed operands), s (IN_WIDTH+1, signed sum).
module gen_adder #(
  parameter int unsigned IN_WIDTH = 64
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  output logic [IN_WIDTH:0]   s
);

  assign s = {a[IN_WIDTH-1], a} + {b[IN_WIDTH-1], b};

endmodule

// File: rtl/spgd_step_accum.sv
// SPGD parameter-update stage: integrates scaled signed steps into a
// persistent actuator accumulator, clamps it to the DAC range and presents
// the DAC code with a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), clear (sync reload),
//   step_in/step_valid/step_ready (step input handshake), gain_shift
//   (right shift sampled at acceptance), dac_code/dac_valid/dac_ready
//   (DAC output handshake), sat (last update clamped).
// Build option: define SPGD_ACC_ROUND_EN for round-half-up DAC code
//   extraction instead of truncation.
module spgd_step_accum
  import spgd_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned            FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned            DAC_WIDTH  = DAC_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = DATA_WIDTH'(ACC_INIT_VALUE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  step_in,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [SHIFT_WIDTH-1:0] gain_shift,
  output logic [DAC_WIDTH-1:0]   dac_code,
  output logic                   dac_valid,
  input  logic                   dac_ready,
  output logic                   sat
);

  localparam int unsigned CODE_LSB = FRAC_BITS;
  localparam int unsigned CODE_MSB = FRAC_BITS + DAC_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] LIMIT_HI =
    {{(DATA_WIDTH - DAC_WIDTH - FRAC_BITS){1'b0}}, {DAC_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [DAC_WIDTH-1:0] INIT_CODE = INIT_VALUE[CODE_MSB:CODE_LSB];

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0]  step_q, step_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  scaled_q, scaled_d;
  logic [DATA_WIDTH:0]    sum_q, sum_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DAC_WIDTH-1:0]   code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   sat_q, sat_d;
  logic                   ready_q, ready_d;

  logic [DATA_WIDTH:0]    sum_c;
  logic [DATA_WIDTH-1:0]  clamped_c;
  logic                   clamp_sat_c;
  logic [DAC_WIDTH-1:0]   code_c;

  // Non-wrapping accumulate; sum_c[DATA_WIDTH] carries the true sign.
  gen_adder #(.IN_WIDTH(DATA_WIDTH)) u_add (
    .a (acc_q),
    .b (scaled_q),
    .s (sum_c)
  );

  // Clamp the registered sum to [0, LIMIT_HI].
  always_comb begin
    clamped_c   = sum_q[DATA_WIDTH-1:0];
    clamp_sat_c = 1'b0;
    if (sum_q[DATA_WIDTH]) begin
      clamped_c   = '0;
      clamp_sat_c = 1'b1;
    end else if (sum_q > {1'b0, LIMIT_HI}) begin
      clamped_c   = LIMIT_HI;
      clamp_sat_c = 1'b1;
    end
  end

`ifdef SPGD_ACC_ROUND_EN
  // Round half up; only full scale plus a half LSB can carry out.
  logic [DAC_WIDTH:0] rounded_c;
  assign rounded_c = {1'b0, clamped_c[CODE_MSB:CODE_LSB]} +
                     (DAC_WIDTH+1)'(clamped_c[FRAC_BITS-1]);
  assign code_c    = rounded_c[DAC_WIDTH] ? {DAC_WIDTH{1'b1}} : rounded_c[DAC_WIDTH-1:0];
`else
  assign code_c = clamped_c[CODE_MSB:CODE_LSB];
`endif

  // Next-state and output decode; clear overrides any in-flight operation.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    shift_d  = shift_q;
    scaled_d = scaled_q;
    sum_d    = sum_q;
    acc_d    = acc_q;
    code_d   = code_q;
    valid_d  = valid_q;
    sat_d    = sat_q;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (step_valid && ready_q) begin
          step_d  = step_in;
          shift_d = gain_shift;
          state_d = SCALE;
        end
      end
      SCALE: begin
        scaled_d = DATA_WIDTH'($signed(step_q) >>> shift_q);
        state_d  = ADD;
      end
      ADD: begin
        sum_d   = sum_c;
        state_d = CLAMP;
      end
      CLAMP: begin
        acc_d   = clamped_c;
        code_d  = code_c;
        sat_d   = clamp_sat_c;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (dac_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      acc_d   = INIT_VALUE;
      code_d  = INIT_CODE;
      valid_d = 1'b0;
      sat_d   = 1'b0;
    end

    ready_d = (state_d == IDLE) && !clear;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      shift_q  <= '0;
      scaled_q <= '0;
      sum_q    <= '0;
      acc_q    <= INIT_VALUE;
      code_q   <= INIT_CODE;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      shift_q  <= shift_d;
      scaled_q <= scaled_d;
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      ready_q  <= ready_d;
    end
  end

  assign step_ready = ready_q;
  assign dac_code   = code_q;
  assign dac_valid  = valid_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_spgd_step_accum.sv
// Bench for spgd_step_accum: directed and random steps checked against a
// plain-arithmetic model of the accumulator (clamp and code extraction).
// Honours SPGD_ACC_ROUND_EN the same way the design does.
module tb_spgd_step_accum;

  localparam logic [63:0] INIT = 64'h0800_0000_0000_0000;
  localparam logic [63:0] LIM  = 64'h0FFF_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [63:0] step_in;
  logic        step_valid;
  logic        step_ready;
  logic [5:0]  gain_shift;
  logic [11:0] dac_code;
  logic        dac_valid;
  logic        dac_ready;
  logic        sat;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_acc;
  logic        m_sat;

  spgd_step_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .step_in    (step_in),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .gain_shift (gain_shift),
    .dac_code   (dac_code),
    .dac_valid  (dac_valid),
    .dac_ready  (dac_ready),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_code(input logic [63:0] a);
    longint unsigned r;
`ifdef SPGD_ACC_ROUND_EN
    r = (a + 64'h0000_8000_0000_0000) >> 48;
    if (r > 64'd4095) r = 64'd4095;
`else
    r = a >> 48;
`endif
    return 12'(r);
  endfunction

  // Reference: scale, add at 65 bits, clamp to [0, LIM].
  task automatic model_step(input logic [63:0] s, input int sh);
    logic signed [64:0] sum;
    sum = $signed({1'b0, m_acc}) + ($signed({s[63], s}) >>> sh);
    if (sum < 0) begin
      m_acc = 64'd0; m_sat = 1'b1;
    end else if (sum > $signed({1'b0, LIM})) begin
      m_acc = LIM;   m_sat = 1'b1;
    end else begin
      m_acc = sum[63:0]; m_sat = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (step_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_step_ready", 64'(step_ready), 64'd1);
  endtask

  // One full transaction; pre=1 holds dac_ready high from before acceptance.
  task automatic do_step(input logic [63:0] s, input int sh, input int hold, input bit pre);
    wait_ready();
    step_in    = s;
    gain_shift = 6'(sh);
    step_valid = 1'b1;
    dac_ready  = pre;
    @(negedge clk);
    step_valid = 1'b0;
    step_in    = {$urandom, $urandom};
    gain_shift = 6'($urandom_range(0, 63));
    model_step(s, sh);
    chk("busy_ready", 64'(step_ready), 64'd0);
    @(negedge clk);
    chk("lat1_valid", 64'(dac_valid), 64'd0);
    @(negedge clk);
    chk("lat2_valid", 64'(dac_valid), 64'd0);
    @(negedge clk);
    chk("lat3_valid", 64'(dac_valid), 64'd1);
    chk("code", 64'(dac_code), 64'(m_code(m_acc)));
    chk("sat", 64'(sat), 64'(m_sat));
    if (!pre) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 64'(dac_valid), 64'd1);
        chk("hold_code", 64'(dac_code), 64'(m_code(m_acc)));
      end
      dac_ready = 1'b1;
    end
    @(negedge clk);
    dac_ready = 1'b0;
    chk("consumed_valid", 64'(dac_valid), 64'd0);
    chk("consumed_ready", 64'(step_ready), 64'd1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_acc = INIT;
    m_sat = 1'b0;
    chk("clr_code", 64'(dac_code), 64'h800);
    chk("clr_valid", 64'(dac_valid), 64'd0);
    chk("clr_sat", 64'(sat), 64'd0);
    chk("clr_ready_low", 64'(step_ready), 64'd0);
    @(negedge clk);
    chk("clr_ready_back", 64'(step_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; step_in = '0; step_valid = 1'b0;
    gain_shift = '0; dac_ready = 1'b0;
    m_acc = INIT; m_sat = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_code", 64'(dac_code), 64'h800);
    chk("rst_valid", 64'(dac_valid), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_ready", 64'(step_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", 64'(step_ready), 64'd1);

    // Basic step with dac_ready held low
    do_step(64'h0001_0000_0000_0000, 0, 5, 1'b0);
    chk("basic_code", 64'(dac_code), 64'h801);

    // Half steps from the initial value
    pulse_clear();
    do_step(64'h0000_8000_0000_0000, 0, 1, 1'b0);
`ifdef SPGD_ACC_ROUND_EN
    chk("half1_code", 64'(dac_code), 64'h801);
`else
    chk("half1_code", 64'(dac_code), 64'h800);
`endif
    do_step(64'h0000_8000_0000_0000, 0, 0, 1'b0);
    chk("half2_code", 64'(dac_code), 64'h801);

    // Saturation both ways
    do_step(64'h0F00_0000_0000_0000, 0, 1, 1'b0);
    chk("sathi_code", 64'(dac_code), 64'hFFF);
    chk("sathi_sat", 64'(sat), 64'd1);
    do_step(64'hF000_0000_0000_0000, 0, 1, 1'b1);
    chk("satlo_code", 64'(dac_code), 64'h000);
    chk("satlo_sat", 64'(sat), 64'd1);

    // Shifted step
    pulse_clear();
    do_step(64'h0010_0000_0000_0000, 4, 2, 1'b0);
    chk("shift_code", 64'(dac_code), 64'h801);

    // Same step, discarded by clear while in ADD
    wait_ready();
    step_in = 64'h0010_0000_0000_0000; gain_shift = 6'd4; step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_acc = INIT; m_sat = 1'b0;
    chk("clradd_valid", 64'(dac_valid), 64'd0);
    chk("clradd_code", 64'(dac_code), 64'h800);
    chk("clradd_ready_low", 64'(step_ready), 64'd0);
    @(negedge clk);
    chk("clradd_ready", 64'(step_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clradd_no_valid", 64'(dac_valid), 64'd0);
    end

    // Randomized steps against the model
    for (int n = 0; n < 40; n++) begin
      logic [63:0] s;
      int sh;
      s  = {$urandom, $urandom};
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(9, 16));
      do_step(s, sh, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an operation
    wait_ready();
    step_in = 64'h0100_0000_0000_0000; gain_shift = 6'd0; step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_acc = INIT; m_sat = 1'b0;
    chk("midrst_code", 64'(dac_code), 64'h800);
    chk("midrst_valid", 64'(dac_valid), 64'd0);
    chk("midrst_ready", 64'(step_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_rise", 64'(step_ready), 64'd1);
    do_step(64'h0002_0000_0000_0000, 0, 0, 1'b0);
    chk("midrst_next_code", 64'(dac_code), 64'h802);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
